spin_commit_stage: RTL and testbench
====================================

Name: spin_commit_stage

Overview:
- Sits directly downstream of the energy FIFO maintainer in the flip manager. It consumes each candidate spin together with its push-none verdict.
- It commits the spin as the new working spin when energy did not worsen (push_none=0), or discards it and keeps the previous working spin (push_none=1).
- It reissues the working spin to the spin-update path each iteration.
- It counts consecutive rejected iterations and declares convergence when a programmable threshold is reached.

Parameters:
- DATASPIN, 256, bit width of a spin vector
- CNT_W, 16, width of the stall, accept and reject counters and of the threshold

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  stage enable; when low, no handshake completes on either side
- flush_i  in  1  synchronous clear of state, counters and pending output
- load_valid_i  in  1  initial spin load request
- load_spin_i  in  DATASPIN  initial spin value
- load_ready_o  out  1  load accepted when high together with load_valid_i
- stall_threshold_i  in  CNT_W  consecutive-reject limit; 0 disables convergence detection
- spin_valid_i  in  1  candidate spin valid, from the maintainer
- spin_i  in  DATASPIN  candidate spin
- spin_push_none_i  in  1  1 = reject candidate, 0 = commit
- spin_ready_o  out  1  ready toward the maintainer
- spin_valid_o  out  1  working spin available downstream
- spin_o  out  DATASPIN  working (committed) spin
- spin_ready_i  in  1  downstream ready
- converged_o  out  1  convergence reached
- accept_cnt_o  out  CNT_W  commits since last load/flush
- reject_cnt_o  out  CNT_W  rejects since last load/flush

Behaviour:
- Reset values (async, rst_ni=0): state IDLE; working spin 0; all counters 0; all of the following 0: spin_valid_o, spin_ready_o, converged_o, load_ready_o.
- FSM states:
  - IDLE: load_ready_o = en_i. All other ready/valid outputs 0.
  - RUN: load_ready_o = 0. spin_ready_o = en_i & ~out_pending. spin_valid_o = out_pending.
  - CONVERGED: converged_o = 1. spin_ready_o = 0, spin_valid_o = 0, load_ready_o = 0.
- Load handshake in IDLE: working spin <= load_spin_i; stall, accept and reject counters cleared; out_pending <= 1; next state RUN. spin_valid_o rises the following cycle (1-cycle latency).
- Output handshake: spin_valid_o & spin_ready_i clears out_pending. spin_o always equals the working-spin register, which is stable while spin_valid_o is high.
- Input handshake in RUN (spin_valid_i & spin_ready_o):
  - push_none=0: working spin <= spin_i; stall <= 0; accept_cnt += 1.
  - push_none=1: working spin unchanged; stall += 1; reject_cnt += 1.
  - In either case out_pending <= 1, so exactly one output token is produced per input token.
- Because spin_ready_o requires ~out_pending, input and output tokens strictly alternate. No input is accepted in the cycle out_pending is cleared; the earliest acceptance is the next cycle.
- Convergence: on a reject handshake where stall+1 == stall_threshold_i and the threshold is not 0:
  - next state CONVERGED; out_pending <= 0 (no final token issued).
  - counters hold; working spin holds and remains readable on spin_o.
- Counters saturate at 2^CNT_W-1; no wrap-around. stall saturates too. If the threshold exceeds the reachable count, convergence never triggers.
- flush_i:
  - From any state, next state IDLE; out_pending 0; counters 0; converged_o 0. Working spin is retained.
  - flush_i has priority over any simultaneous load or spin handshake, and that handshake is discarded.
- en_i low: all ready outputs forced 0. spin_valid_o stays as is (a token already pending remains visible); the output handshake still requires en_i.
- Changing stall_threshold_i mid-RUN takes effect on the next reject handshake.

Test Plan:
- Reset, then load 0xA5..A5 with threshold 3:
  - spin_valid_o=1 one cycle after load; spin_o=0xA5..A5.
  - Downstream accepts; spin_ready_o=1 next cycle.
- Commit path: input spin 0x0F..0F with push_none=0 → next output spin_o=0x0F..0F; accept_cnt=1, reject_cnt=0.
- Reject path: input 0xFF..FF with push_none=1 → spin_o stays 0x0F..0F; reject_cnt=1.
- Convergence:
  - Sequence, threshold 3: reject, reject, commit, then three rejects.
  - Expected: converged_o goes high after the 6th input handshake; accept_cnt=1, reject_cnt=5.
  - No output token is issued after the final reject.
- Backpressure: spin_ready_i held 0 for 5 cycles → spin_valid_o and spin_o stable throughout; spin_ready_o=0 throughout.
- Flush:
  - flush_i asserted in the same cycle as an input handshake → state IDLE; counters 0; converged_o 0.
  - That candidate is not committed; load_ready_o=1 next cycle.
  - Also: rst_ni pulsed low mid-RUN → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/spin_commit_stage.sv
// spin_commit_stage
// Commits or discards candidate spins from the energy FIFO maintainer, reissues
// the working spin downstream once per accepted candidate, and declares
// convergence after a programmable number of consecutive rejects.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   en_i                   stage enable (gates every handshake)
//   flush_i                synchronous clear back to IDLE (working spin kept)
//   load_valid_i/_spin_i   initial spin load, accepted with load_ready_o
//   stall_threshold_i      consecutive-reject limit, 0 disables convergence
//   spin_valid_i/spin_i/spin_push_none_i/spin_ready_o  candidate input
//   spin_valid_o/spin_o/spin_ready_i                   working spin output
//   converged_o, accept_cnt_o, reject_cnt_o            status
module spin_commit_stage #(
  parameter int DATASPIN = 256,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic                load_valid_i,
  input  logic [DATASPIN-1:0] load_spin_i,
  output logic                load_ready_o,
  input  logic [CNT_W-1:0]    stall_threshold_i,
  input  logic                spin_valid_i,
  input  logic [DATASPIN-1:0] spin_i,
  input  logic                spin_push_none_i,
  output logic                spin_ready_o,
  output logic                spin_valid_o,
  output logic [DATASPIN-1:0] spin_o,
  input  logic                spin_ready_i,
  output logic                converged_o,
  output logic [CNT_W-1:0]    accept_cnt_o,
  output logic [CNT_W-1:0]    reject_cnt_o
);

  typedef enum logic [1:0] {IDLE, RUN, CONVERGED} state_t;

  state_t                r_state;
  logic [DATASPIN-1:0]   r_spin;
  logic [CNT_W-1:0]      r_stall;
  logic [CNT_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_rej;
  logic                  r_pending;

  state_t                w_state_next;
  logic [DATASPIN-1:0]   w_spin_next;
  logic [CNT_W-1:0]      w_stall_next;
  logic [CNT_W-1:0]      w_acc_next;
  logic [CNT_W-1:0]      w_rej_next;
  logic                  w_pending_next;
  logic                  w_load_hs;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic [CNT_W:0]        w_stall_plus;
  logic                  w_conv_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // One bit wider so a saturated stall count can never alias a threshold.
  assign w_stall_plus = {1'b0, r_stall} + {{CNT_W{1'b0}}, 1'b1};
  assign w_conv_hit   = (stall_threshold_i != '0) &&
                        (w_stall_plus == {1'b0, stall_threshold_i});

  always_comb begin
    load_ready_o   = 1'b0;
    spin_ready_o   = 1'b0;
    spin_valid_o   = 1'b0;
    converged_o    = 1'b0;
    w_state_next   = r_state;
    w_spin_next    = r_spin;
    w_stall_next   = r_stall;
    w_acc_next     = r_acc;
    w_rej_next     = r_rej;
    w_pending_next = r_pending;

    case (r_state)
      IDLE: begin
        // Gated by reset so the output is low while reset is held.
        load_ready_o = en_i & rst_ni;
      end
      RUN: begin
        spin_ready_o = en_i & ~r_pending;
        spin_valid_o = r_pending;
      end
      CONVERGED: begin
        converged_o = 1'b1;
      end
      default: ;
    endcase

    w_load_hs = load_valid_i & load_ready_o;
    w_in_hs   = spin_valid_i & spin_ready_o;
    w_out_hs  = spin_valid_o & spin_ready_i & en_i;

    if (w_out_hs) w_pending_next = 1'b0;

    if (flush_i) begin
      w_state_next   = IDLE;
      w_pending_next = 1'b0;
      w_stall_next   = '0;
      w_acc_next     = '0;
      w_rej_next     = '0;
    end else if (w_load_hs) begin
      w_state_next   = RUN;
      w_spin_next    = load_spin_i;
      w_stall_next   = '0;
      w_acc_next     = '0;
      w_rej_next     = '0;
      w_pending_next = 1'b1;
    end else if (w_in_hs) begin
      w_pending_next = 1'b1;
      if (!spin_push_none_i) begin
        w_spin_next  = spin_i;
        w_stall_next = '0;
        w_acc_next   = sat_inc(r_acc);
      end else begin
        w_stall_next = sat_inc(r_stall);
        w_rej_next   = sat_inc(r_rej);
        if (w_conv_hit) begin
          // Converged: no final token, everything else freezes.
          w_state_next   = CONVERGED;
          w_pending_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_spin    <= '0;
      r_stall   <= '0;
      r_acc     <= '0;
      r_rej     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_spin    <= w_spin_next;
      r_stall   <= w_stall_next;
      r_acc     <= w_acc_next;
      r_rej     <= w_rej_next;
      r_pending <= w_pending_next;
    end
  end

  assign spin_o       = r_spin;
  assign accept_cnt_o = r_acc;
  assign reject_cnt_o = r_rej;

endmodule

// File: tb/tb_spin_commit_stage.sv
module tb_spin_commit_stage;
  localparam int DS = 256;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          flush_i;
  logic          load_valid_i;
  logic [DS-1:0] load_spin_i;
  logic          load_ready_o;
  logic [CW-1:0] stall_threshold_i;
  logic          spin_valid_i;
  logic [DS-1:0] spin_i;
  logic          spin_push_none_i;
  logic          spin_ready_o;
  logic          spin_valid_o;
  logic [DS-1:0] spin_o;
  logic          spin_ready_i;
  logic          converged_o;
  logic [CW-1:0] accept_cnt_o;
  logic [CW-1:0] reject_cnt_o;

  int errors = 0;
  int checks = 0;

  logic [DS-1:0] pat_a5, pat_0f, pat_ff, pat_33, pat_11, pat_22, pat_3c;

  always #5 clk_i = ~clk_i;

  spin_commit_stage #(.DATASPIN(DS), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .load_valid_i(load_valid_i), .load_spin_i(load_spin_i), .load_ready_o(load_ready_o),
    .stall_threshold_i(stall_threshold_i),
    .spin_valid_i(spin_valid_i), .spin_i(spin_i), .spin_push_none_i(spin_push_none_i),
    .spin_ready_o(spin_ready_o), .spin_valid_o(spin_valid_o), .spin_o(spin_o),
    .spin_ready_i(spin_ready_i), .converged_o(converged_o),
    .accept_cnt_o(accept_cnt_o), .reject_cnt_o(reject_cnt_o)
  );

  task automatic chk(input string tag, input logic [DS-1:0] obs, input logic [DS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one candidate for one cycle; the stage must be ready for it.
  task automatic send(input string tag, input logic [DS-1:0] v, input logic pn);
    chk({tag, "_rdy"}, DS'(spin_ready_o), DS'(1'b1));
    spin_valid_i = 1'b1; spin_i = v; spin_push_none_i = pn;
    @(negedge clk_i);
    spin_valid_i = 1'b0; spin_push_none_i = 1'b0;
  endtask

  // Let downstream take the pending token; the stage is ready again afterwards.
  task automatic drain(input string tag);
    spin_ready_i = 1'b1;
    @(negedge clk_i);
    spin_ready_i = 1'b0;
    chk({tag, "_vld0"}, DS'(spin_valid_o), DS'(1'b0));
    chk({tag, "_rdy1"}, DS'(spin_ready_o), DS'(1'b1));
  endtask

  task automatic do_load(input logic [DS-1:0] v);
    load_valid_i = 1'b1; load_spin_i = v;
    @(negedge clk_i);
    load_valid_i = 1'b0;
  endtask

  initial begin
    pat_a5 = {32{8'hA5}}; pat_0f = {32{8'h0F}}; pat_ff = {32{8'hFF}};
    pat_33 = {32{8'h33}}; pat_11 = {32{8'h11}}; pat_22 = {32{8'h22}};
    pat_3c = {32{8'h3C}};
    rst_ni = 1'b0; en_i = 1'b1; flush_i = 1'b0; load_valid_i = 1'b0; load_spin_i = '0;
    stall_threshold_i = 16'd3; spin_valid_i = 1'b0; spin_i = '0;
    spin_push_none_i = 1'b0; spin_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_load_rdy", DS'(load_ready_o), '0);
    chk("rst_vld", DS'(spin_valid_o), '0);
    chk("rst_rdy", DS'(spin_ready_o), '0);
    chk("rst_conv", DS'(converged_o), '0);
    chk("rst_spin", spin_o, '0);
    chk("rst_acc", DS'(accept_cnt_o), '0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_load_rdy", DS'(load_ready_o), DS'(1'b1));

    // Load A5 with threshold 3
    do_load(pat_a5);
    chk("load_vld", DS'(spin_valid_o), DS'(1'b1));
    chk("load_spin", spin_o, pat_a5);
    chk("load_rdy0", DS'(spin_ready_o), '0);
    chk("load_lrdy0", DS'(load_ready_o), '0);
    drain("load_drain");

    // Commit path
    send("commit", pat_0f, 1'b0);
    chk("commit_vld", DS'(spin_valid_o), DS'(1'b1));
    chk("commit_spin", spin_o, pat_0f);
    chk("commit_acc", DS'(accept_cnt_o), DS'(16'd1));
    chk("commit_rej", DS'(reject_cnt_o), '0);
    drain("commit_drain");

    // Reject path
    send("reject", pat_ff, 1'b1);
    chk("reject_vld", DS'(spin_valid_o), DS'(1'b1));
    chk("reject_spin", spin_o, pat_0f);
    chk("reject_rej", DS'(reject_cnt_o), DS'(16'd1));
    chk("reject_acc", DS'(accept_cnt_o), DS'(16'd1));

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_vld", DS'(spin_valid_o), DS'(1'b1));
      chk("bp_spin", spin_o, pat_0f);
      chk("bp_rdy", DS'(spin_ready_o), '0);
    end

    // Enable low: downstream ready is ignored, token stays visible
    en_i = 1'b0; spin_ready_i = 1'b1;
    @(negedge clk_i);
    chk("en0_vld", DS'(spin_valid_o), DS'(1'b1));
    chk("en0_rdy", DS'(spin_ready_o), '0);
    en_i = 1'b1; spin_ready_i = 1'b0;
    drain("en1_drain");

    // Flush together with an input handshake: candidate is discarded
    spin_valid_i = 1'b1; spin_i = pat_33; spin_push_none_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    spin_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_lrdy", DS'(load_ready_o), DS'(1'b1));
    chk("flush_acc", DS'(accept_cnt_o), '0);
    chk("flush_rej", DS'(reject_cnt_o), '0);
    chk("flush_conv", DS'(converged_o), '0);
    chk("flush_vld", DS'(spin_valid_o), '0);
    chk("flush_spin", spin_o, pat_0f);

    // Convergence: R R C R R R with threshold 3
    do_load(pat_a5);
    drain("cv_drain0");
    send("cv1", pat_11, 1'b1); drain("cv1_drain");
    send("cv2", pat_22, 1'b1);
    chk("cv2_conv", DS'(converged_o), '0);
    drain("cv2_drain");
    send("cv3", pat_3c, 1'b0); drain("cv3_drain");
    send("cv4", pat_11, 1'b1); drain("cv4_drain");
    send("cv5", pat_22, 1'b1);
    chk("cv5_conv", DS'(converged_o), '0);
    drain("cv5_drain");
    send("cv6", pat_ff, 1'b1);
    chk("cv6_conv", DS'(converged_o), DS'(1'b1));
    chk("cv6_vld", DS'(spin_valid_o), '0);
    chk("cv6_rdy", DS'(spin_ready_o), '0);
    chk("cv6_spin", spin_o, pat_3c);
    chk("cv6_acc", DS'(accept_cnt_o), DS'(16'd1));
    chk("cv6_rej", DS'(reject_cnt_o), DS'(16'd5));
    spin_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    spin_ready_i = 1'b0;
    chk("cv_hold_vld", DS'(spin_valid_o), '0);
    chk("cv_hold_conv", DS'(converged_o), DS'(1'b1));
    chk("cv_hold_lrdy", DS'(load_ready_o), '0);

    // Flush out of CONVERGED
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("cflush_conv", DS'(converged_o), '0);
    chk("cflush_lrdy", DS'(load_ready_o), DS'(1'b1));
    chk("cflush_rej", DS'(reject_cnt_o), '0);

    // Asynchronous reset mid-RUN with a pending token
    do_load(pat_a5);
    chk("ar_vld_pre", DS'(spin_valid_o), DS'(1'b1));
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_vld", DS'(spin_valid_o), '0);
    chk("ar_spin", spin_o, '0);
    chk("ar_lrdy", DS'(load_ready_o), '0);
    chk("ar_rdy", DS'(spin_ready_o), '0);
    chk("ar_acc", DS'(accept_cnt_o), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
